// File: rtl/uart_link_pkg.sv
// Shared constants, state encodings and helpers for the uart_link transceiver.
package uart_link_pkg;

   localparam int OVS        = 16;
   localparam int FRAME_BITS = 10;

   localparam logic [3:0] SAMPLE_LO  = 4'd7;
   localparam logic [3:0] SAMPLE_MID = 4'd8;
   localparam logic [3:0] SAMPLE_HI  = 4'd9;
   localparam logic [3:0] TICK_LAST  = 4'd15;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_t;

   typedef enum logic {
      TX_IDLE  = 1'b0,
      TX_SHIFT = 1'b1
   } tx_state_t;

   function automatic logic majority3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter; first-word-fall-through read so
// the head byte is available in the same cycle it is popped.
module uart_tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       srst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
      end
   endgenerate

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   // Extra MSB on each pointer distinguishes full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/uart_link.sv
// 8N1 UART transceiver: 16x oversampled majority-vote receiver and a
// FIFO-buffered transmitter that sends queued bytes back to back.
module uart_link
   import uart_link_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int OVS_DIV  = CLK_FREQ / (BAUD * OVS),
   parameter int TX_DEPTH = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic       uart_rec,
   output logic [7:0] uart_data_out,
   input  logic       uart_send,
   input  logic [7:0] uart_data_in,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       rx_frame_err,
   output logic       tx_drop
);

   localparam int OVS_W    = (OVS_DIV < 2) ? 1 : $clog2(OVS_DIV);
   localparam int BIT_CLKS = OVS * OVS_DIV;
   localparam int BAUD_W   = $clog2(BIT_CLKS);

   generate
      if (OVS_DIV < 2) begin : g_bad_div
         $error("uart_link: OVS_DIV must be >= 2");
      end
   endgenerate

   // ---------------- RX ----------------
   logic             rxd_meta_q, rxd_sync_q;
   rx_state_t        rx_state_q, rx_state_d;
   logic [OVS_W-1:0] rx_ovs_q, rx_ovs_d;
   logic [3:0]       rx_tick_q, rx_tick_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [2:0]       rx_vote_q, rx_vote_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_rec_q, rx_rec_d;
   logic             rx_err_q, rx_err_d;
   logic             rx_tick_start, rx_tick_end;

   // Samples are taken on the first clock of a tick; bit boundaries move on its last clock.
   assign rx_tick_start = (rx_ovs_q == '0);
   assign rx_tick_end   = (rx_ovs_q == OVS_W'(OVS_DIV - 1));

   always_comb begin
      rx_state_d = rx_state_q;
      rx_ovs_d   = rx_ovs_q;
      rx_tick_d  = rx_tick_q;
      rx_bit_d   = rx_bit_q;
      rx_vote_d  = rx_vote_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_rec_d   = 1'b0;
      rx_err_d   = 1'b0;

      if (rx_state_q != RX_IDLE) begin
         if (rx_tick_end) begin
            rx_ovs_d  = '0;
            rx_tick_d = rx_tick_q + 4'd1;
         end else begin
            rx_ovs_d = rx_ovs_q + OVS_W'(1);
         end
      end

      case (rx_state_q)
         RX_IDLE: begin
            rx_ovs_d  = '0;
            rx_tick_d = '0;
            if (!rxd_sync_q) begin
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_tick_start && rx_tick_q == SAMPLE_MID && rxd_sync_q) begin
               rx_state_d = RX_IDLE;
            end else if (rx_tick_end && rx_tick_q == TICK_LAST) begin
               rx_state_d = RX_DATA;
               rx_bit_d   = '0;
            end
         end
         RX_DATA: begin
            if (rx_tick_start) begin
               if (rx_tick_q == SAMPLE_LO)  rx_vote_d[0] = rxd_sync_q;
               if (rx_tick_q == SAMPLE_MID) rx_vote_d[1] = rxd_sync_q;
               if (rx_tick_q == SAMPLE_HI)  rx_vote_d[2] = rxd_sync_q;
            end
            if (rx_tick_end && rx_tick_q == TICK_LAST) begin
               rx_shift_d = {majority3(rx_vote_q), rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (rx_tick_start && rx_tick_q == SAMPLE_MID) begin
               if (rxd_sync_q) begin
                  rx_data_d  = rx_shift_q;
                  rx_rec_d   = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_err_d   = 1'b1;
                  rx_state_d = RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            if (rxd_sync_q) begin
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_ovs_q   <= '0;
         rx_tick_q  <= '0;
         rx_bit_q   <= '0;
         rx_vote_q  <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_rec_q   <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         rxd_meta_q <= uart_rxd;
         rxd_sync_q <= rxd_meta_q;
         rx_state_q <= rx_state_d;
         rx_ovs_q   <= rx_ovs_d;
         rx_tick_q  <= rx_tick_d;
         rx_bit_q   <= rx_bit_d;
         rx_vote_q  <= rx_vote_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_rec_q   <= rx_rec_d;
         rx_err_q   <= rx_err_d;
      end
   end

   assign uart_rec      = rx_rec_q;
   assign uart_data_out = rx_data_q;
   assign rx_frame_err  = rx_err_q;

   // ---------------- TX ----------------
   tx_state_t         tx_state_q, tx_state_d;
   logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
   logic [3:0]        tx_bit_q, tx_bit_d;
   logic [8:0]        tx_shift_q, tx_shift_d;
   logic              txd_q, txd_d;
   logic              tx_drop_q, tx_drop_d;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]        fifo_dout;

   uart_tx_fifo #(
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (sys_clk),
      .srst  (sys_rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (uart_data_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The start bit goes straight into txd; the shifter holds data plus stop bit.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      fifo_pop   = 1'b0;

      case (tx_state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_shift_d = {1'b1, fifo_dout};
               txd_d      = 1'b0;
               tx_bit_d   = '0;
               tx_baud_d  = '0;
               tx_state_d = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (tx_baud_q == BAUD_W'(BIT_CLKS - 1)) begin
               tx_baud_d = '0;
               if (tx_bit_q == 4'(FRAME_BITS - 1)) begin
                  if (!fifo_empty) begin
                     fifo_pop   = 1'b1;
                     tx_shift_d = {1'b1, fifo_dout};
                     txd_d      = 1'b0;
                     tx_bit_d   = '0;
                  end else begin
                     txd_d      = 1'b1;
                     tx_state_d = TX_IDLE;
                  end
               end else begin
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = {1'b1, tx_shift_q[8:1]};
                  tx_bit_d   = tx_bit_q + 4'd1;
               end
            end else begin
               tx_baud_d = tx_baud_q + BAUD_W'(1);
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      fifo_push = uart_send && (!fifo_full || fifo_pop);
      tx_drop_d = uart_send && fifo_full && !fifo_pop;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         tx_state_q <= TX_IDLE;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
         txd_q      <= 1'b1;
         tx_drop_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         tx_drop_q  <= tx_drop_d;
      end
   end

   assign uart_txd = txd_q;
   assign tx_ready = !fifo_full;
   assign tx_busy  = (tx_state_q != TX_IDLE) || !fifo_empty;
   assign tx_drop  = tx_drop_q;

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link at 7.3728 MHz / 115200 baud (64 clocks per bit).
module tb_uart_link;

   localparam int BIT_CLKS = 64;
   localparam int FRAME    = 640;
   localparam int LOG_N    = 6000;

   logic       sys_clk      = 1'b0;
   logic       sys_rst      = 1'b1;
   logic       uart_rxd     = 1'b1;
   logic       uart_send    = 1'b0;
   logic [7:0] uart_data_in = 8'h00;
   logic       uart_txd, uart_rec, tx_ready, tx_busy, rx_frame_err, tx_drop;
   logic [7:0] uart_data_out;

   uart_link #(
      .CLK_FREQ (7372800),
      .BAUD     (115200)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .uart_rxd      (uart_rxd),
      .uart_txd      (uart_txd),
      .uart_rec      (uart_rec),
      .uart_data_out (uart_data_out),
      .uart_send     (uart_send),
      .uart_data_in  (uart_data_in),
      .tx_ready      (tx_ready),
      .tx_busy       (tx_busy),
      .rx_frame_err  (rx_frame_err),
      .tx_drop       (tx_drop)
   );

   always #5 sys_clk = ~sys_clk;

   int vec_cnt     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int rec_cnt     = 0;
   int err_cnt     = 0;
   int rec_cyc     = 0;

   logic tx_rec_en = 1'b0;
   int   tx_idx    = 0;
   logic txd_log   [LOG_N];
   logic busy_log  [LOG_N];
   logic ready_log [LOG_N];
   logic drop_log  [LOG_N];
   logic [7:0] tx_exp [9];

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Output monitor, sampling 1 time unit after each rising edge.
   always @(posedge sys_clk) begin
      #1;
      if (uart_rec) begin
         rec_cnt = rec_cnt + 1;
         rec_cyc = cyc;
      end
      if (rx_frame_err) err_cnt = err_cnt + 1;
      if (!tx_rec_en) begin
         tx_idx = 0;
      end else if (tx_idx < LOG_N) begin
         txd_log[tx_idx]   = uart_txd;
         busy_log[tx_idx]  = tx_busy;
         ready_log[tx_idx] = tx_ready;
         drop_log[tx_idx]  = tx_drop;
         tx_idx = tx_idx + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic rx_frame(input logic [7:0] data, input logic stop, output int edge_cyc);
      uart_rxd = 1'b0;
      edge_cyc = cyc;
      ticks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = data[i];
         ticks(BIT_CLKS);
      end
      uart_rxd = stop;
      ticks(BIT_CLKS);
      if (!stop) ticks(128);
      uart_rxd = 1'b1;
      ticks(2 * BIT_CLKS);
   endtask

   task automatic find_start(output int start);
      start = -1;
      for (int k = 0; k < LOG_N; k++) begin
         if (start < 0 && txd_log[k] === 1'b0) start = k;
      end
   endtask

   // Compares every clock of each frame bit against {stop, data LSB-first, start}.
   task automatic check_frames(input int start, input int nframes);
      for (int f = 0; f < nframes; f++) begin
         for (int b = 0; b < 10; b++) begin
            logic [7:0] byte_v;
            logic       e;
            int         bad;
            byte_v = tx_exp[f];
            e   = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byte_v[b-1];
            bad = 0;
            for (int j = 0; j < BIT_CLKS; j++) begin
               if (txd_log[start + f*FRAME + b*BIT_CLKS + j] !== e) bad++;
            end
            check($sformatf("tx_frame%0d_bit%0d_bad_clocks", f, b), bad, 0);
         end
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_rec;
      int         exp_err;
      logic [7:0] exp_out;
   } rx_vec_t;

   rx_vec_t rx_vecs [6];

   initial begin
      int edge_c, rec0, err0, lat, start, bad;

      rx_vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      rx_vecs[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
      rx_vecs[2] = '{8'h81, 1'b0, 0, 1, 8'h3C};
      rx_vecs[3] = '{8'h7E, 1'b1, 1, 0, 8'h7E};
      rx_vecs[4] = '{8'h00, 1'b1, 1, 0, 8'h00};
      rx_vecs[5] = '{8'hFF, 1'b1, 1, 0, 8'hFF};

      // Reset state
      ticks(3);
      check("rst_txd", uart_txd, 1);
      check("rst_data_out", uart_data_out, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_uart_rec", uart_rec, 0);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_frame_err", rx_frame_err, 0);
      check("rst_tx_drop", tx_drop, 0);
      sys_rst = 1'b0;
      ticks(5);

      // RX vectors, with the start-bit glitch sequence before the 0x3C frame
      for (int i = 0; i < 6; i++) begin
         if (i == 1) begin
            rec0 = rec_cnt;
            err0 = err_cnt;
            uart_rxd = 1'b0;
            ticks(12);
            uart_rxd = 1'b1;
            ticks(200);
            check("rx_glitch_rec_pulses", rec_cnt - rec0, 0);
            check("rx_glitch_err_pulses", err_cnt - err0, 0);
            check("rx_glitch_data_out", uart_data_out, 8'hA5);
         end
         rec0 = rec_cnt;
         err0 = err_cnt;
         rx_frame(rx_vecs[i].data, rx_vecs[i].stop, edge_c);
         $display("rx vector %0d: data=0x%02h stop=%0b -> data_out=0x%02h", i,
                  rx_vecs[i].data, rx_vecs[i].stop, uart_data_out);
         check($sformatf("rx%0d_rec_pulses", i), rec_cnt - rec0, rx_vecs[i].exp_rec);
         check($sformatf("rx%0d_err_pulses", i), err_cnt - err0, rx_vecs[i].exp_err);
         check($sformatf("rx%0d_data_out", i), uart_data_out, rx_vecs[i].exp_out);
         if (rx_vecs[i].exp_rec == 1) begin
            lat = rec_cyc - edge_c;
            check($sformatf("rx%0d_latency_%0d_in_602_614", i, lat),
                  (lat >= 602 && lat <= 614), 1);
         end
      end

      // TX burst of three bytes
      tx_exp[0] = 8'h55; tx_exp[1] = 8'hAA; tx_exp[2] = 8'h00;
      tx_rec_en = 1'b1;
      uart_send = 1'b1;
      for (int i = 0; i < 3; i++) begin
         uart_data_in = tx_exp[i];
         ticks(1);
      end
      uart_send = 1'b0;
      ticks(1950);
      find_start(start);
      $display("tx burst: start bit at log index %0d", start);
      check("tx4_start_index", start, 1);
      if (start >= 0) begin
         check_frames(start, 3);
         check("tx4_busy_before_end", busy_log[start + 3*FRAME - 1], 1);
         check("tx4_busy_at_end", busy_log[start + 3*FRAME], 0);
      end
      tx_rec_en = 1'b0;
      ticks(3);

      // Overflow: ten pushes back to back
      tx_rec_en = 1'b1;
      uart_send = 1'b1;
      for (int i = 0; i < 10; i++) begin
         uart_data_in = 8'h31 + 8'(i);
         if (i < 9) tx_exp[i] = 8'h31 + 8'(i);
         ticks(1);
      end
      uart_send = 1'b0;
      ticks(5800);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("tx5_drop_after_push%0d", i), drop_log[i], (i == 9));
      end
      check("tx5_ready_after_push7", ready_log[7], 1);
      find_start(start);
      $display("tx overflow: start bit at log index %0d", start);
      check("tx5_start_index", start, 1);
      if (start >= 0) begin
         bad = 0;
         for (int k = 8; k < start + FRAME; k++) begin
            if (ready_log[k] !== 1'b0) bad++;
         end
         check("tx5_ready_low_clocks_bad", bad, 0);
         check("tx5_ready_after_frame0", ready_log[start + FRAME], 1);
         check_frames(start, 9);
         check("tx5_busy_at_end", busy_log[start + 9*FRAME], 0);
      end
      tx_rec_en = 1'b0;
      ticks(3);

      // Reset during bit 4 of a frame with three more bytes queued
      uart_send    = 1'b1;
      uart_data_in = 8'h00;
      ticks(4);
      uart_send = 1'b0;
      ticks(286);
      check("tx6_txd_before_reset", uart_txd, 0);
      check("tx6_busy_before_reset", tx_busy, 1);
      sys_rst = 1'b1;
      ticks(1);
      sys_rst = 1'b0;
      $display("tx reset: txd=%0b busy=%0b ready=%0b", uart_txd, tx_busy, tx_ready);
      check("tx6_txd_after_reset", uart_txd, 1);
      check("tx6_busy_after_reset", tx_busy, 0);
      check("tx6_ready_after_reset", tx_ready, 1);
      bad = 0;
      for (int k = 0; k < 2000; k++) begin
         if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
         ticks(1);
      end
      check("tx6_idle_clocks_bad", bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
